fp_to_int_seq: RTL and testbench



---
 rtl/fp_to_int_seq_pkg.sv | 16 +
 rtl/fp_to_int_seq_round.sv | 56 +++++
 rtl/fp_to_int_seq.sv | 195 +++++++++++++++++++
 tb/tb_fp_to_int_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_to_int_seq_pkg.sv
// Shared types and bf16 field constants for the bf16 -> integer converter.
package fp_to_int_seq_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fp2int_state_e;

endpackage

// File: rtl/fp_to_int_seq_round.sv
// Rounding, range check and flag generation for the converter's ROUND stage.
module fp2int_round #(
  parameter int INT_WIDTH = 32
) (
  input  logic [INT_WIDTH-1:0] mag_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic                 sign_i,
  input  logic                 signed_i,
  input  logic                 rtz_i,
  output logic [INT_WIDTH-1:0] result_o,
  output logic                 nv_o,
  output logic                 nx_o
);

  localparam logic [INT_WIDTH:0] SMAX_MAG = {2'b00, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH:0] SMIN_MAG = {2'b01, {(INT_WIDTH-1){1'b0}}};

  logic                 inc;
  logic                 inexact;
  logic [INT_WIDTH:0]   mag_r;

  always_comb begin
    inc      = ~rtz_i & guard_i & (sticky_i | mag_i[0]);
    inexact  = guard_i | sticky_i;
    // One extra bit so a carry out of the increment shows up as overflow.
    mag_r    = {1'b0, mag_i} + {{INT_WIDTH{1'b0}}, inc};
    result_o = '0;
    nv_o     = 1'b0;
    nx_o     = 1'b0;
    if (signed_i) begin
      if (!sign_i && (mag_r > SMAX_MAG)) begin
        result_o = SMAX_MAG[INT_WIDTH-1:0];
        nv_o     = 1'b1;
      end else if (sign_i && (mag_r > SMIN_MAG)) begin
        result_o = SMIN_MAG[INT_WIDTH-1:0];
        nv_o     = 1'b1;
      end else begin
        result_o = sign_i ? -mag_r[INT_WIDTH-1:0] : mag_r[INT_WIDTH-1:0];
        nx_o     = inexact;
      end
    end else begin
      if (sign_i) begin
        if (mag_r != '0) nv_o = 1'b1;
        else             nx_o = inexact;
      end else if (mag_r[INT_WIDTH]) begin
        result_o = '1;
        nv_o     = 1'b1;
      end else begin
        result_o = mag_r[INT_WIDTH-1:0];
        nx_o     = inexact;
      end
    end
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle bf16 -> signed/unsigned integer converter (fcvt.w / fcvt.wu).
// Define FP2INT_RTZ_EN to add the rtz_i round-toward-zero request port.
//
// state | meaning
// IDLE  | waiting for a request, ready_o=1
// SHIFT | iterative right shift of the aligned significand
// ROUND | RNE/RTZ rounding, range check, flags
// DONE  | result held until consumer accepts
module fp_to_int_seq
  import fp_to_int_seq_pkg::*;
#(
  parameter int INT_WIDTH  = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [15:0]          operand_i,
  input  logic                 signed_i,
`ifdef FP2INT_RTZ_EN
  input  logic                 rtz_i,
`endif
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [INT_WIDTH-1:0] result_o,
  output logic                 nv_o,
  output logic                 nx_o
);

  localparam int ACC_W = INT_WIDTH + 8;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_ROUND = ROUND;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [INT_WIDTH-1:0] SAT_SMAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] SAT_SMIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [5:0]           sh_q, sh_d;
  logic                 sticky_q, sticky_d;
  logic                 sign_q, sign_d;
  logic                 signed_q, signed_d;
  logic                 rtz_q, rtz_d;
  logic [INT_WIDTH-1:0] result_q, result_d;
  logic                 nv_q, nv_d;
  logic                 nx_q, nx_d;

  logic                  op_sign;
  logic [BF16_EXP_W-1:0] op_exp;
  logic [BF16_MAN_W-1:0] op_man;
  logic signed [9:0]     exp_unb;
  logic                  exp_ovf;
  logic [5:0]            sh_init;
  logic [5:0]            step;
  logic [ACC_W-1:0]      shift_mask;
  logic [INT_WIDTH-1:0]  sat_pos, sat_neg;
  logic                  rtz_in;
  logic [INT_WIDTH-1:0]  rnd_result;
  logic                  rnd_nv, rnd_nx;

`ifdef FP2INT_RTZ_EN
  assign rtz_in = rtz_i;
`else
  assign rtz_in = 1'b0;
`endif

  assign op_sign = operand_i[BF16_W-1];
  assign op_exp  = operand_i[BF16_W-2 -: BF16_EXP_W];
  assign op_man  = operand_i[BF16_MAN_W-1:0];
  assign exp_unb = $signed({2'b00, op_exp}) - $signed(10'(BF16_BIAS));
  assign exp_ovf = exp_unb > $signed(10'(INT_WIDTH-1));
  assign sat_pos = signed_i ? SAT_SMAX : '1;
  assign sat_neg = signed_i ? SAT_SMIN : '0;

  // Shifts beyond INT_WIDTH+1 only feed sticky, so the distance is capped there.
  always_comb begin
    if (exp_unb < -10'sd2) sh_init = 6'(INT_WIDTH + 1);
    else                   sh_init = 6'(INT_WIDTH - 1) - exp_unb[5:0];
  end

  always_comb begin
    if (sh_q < 6'(SHIFT_STEP)) step = sh_q;
    else                       step = 6'(SHIFT_STEP);
    shift_mask = ~({ACC_W{1'b1}} << step);
  end

  fp2int_round #(
    .INT_WIDTH(INT_WIDTH)
  ) u_round (
    .mag_i   (acc_q[ACC_W-1:8]),
    .guard_i (acc_q[7]),
    .sticky_i(sticky_q | (|acc_q[6:0])),
    .sign_i  (sign_q),
    .signed_i(signed_q),
    .rtz_i   (rtz_q),
    .result_o(rnd_result),
    .nv_o    (rnd_nv),
    .nx_o    (rnd_nx)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    signed_d = signed_q;
    rtz_d    = rtz_q;
    result_d = result_q;
    nv_d     = nv_q;
    nx_d     = nx_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          sign_d   = op_sign;
          signed_d = signed_i;
          rtz_d    = rtz_in;
          sticky_d = 1'b0;
          result_d = '0;
          nv_d     = 1'b0;
          nx_d     = 1'b0;
          if (op_exp == '1) begin
            result_d = (op_sign && (op_man == '0)) ? sat_neg : sat_pos;
            nv_d     = 1'b1;
            state_d  = ST_DONE;
          end else if (op_exp == '0) begin
            nx_d    = |op_man;
            state_d = ST_DONE;
          end else if (exp_ovf) begin
            result_d = op_sign ? sat_neg : sat_pos;
            nv_d     = 1'b1;
            state_d  = ST_DONE;
          end else begin
            acc_d   = {1'b1, op_man, {INT_WIDTH{1'b0}}};
            sh_d    = sh_init;
            state_d = (sh_init != '0) ? ST_SHIFT : ST_ROUND;
          end
        end
      end
      ST_SHIFT: begin
        acc_d    = acc_q >> step;
        sticky_d = sticky_q | (|(acc_q & shift_mask));
        sh_d     = sh_q - step;
        if (sh_q == step) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = rnd_result;
        nv_d     = rnd_nv;
        nx_d     = rnd_nx;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      sh_q     <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      signed_q <= 1'b0;
      rtz_q    <= 1'b0;
      result_q <= '0;
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      signed_q <= signed_d;
      rtz_q    <= rtz_d;
      result_q <= result_d;
      nv_q     <= nv_d;
      nx_q     <= nx_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;
  assign nv_o     = nv_q;
  assign nx_o     = nx_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Self-checking bench for fp_to_int_seq: directed vector table, handshake/reset
// sequences and randomized operands against an arithmetic reference model.
module tb_fp_to_int_seq;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [15:0]  operand_i;
  logic         signed_i;
`ifdef FP2INT_RTZ_EN
  logic         rtz_i;
`endif
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] result_o;
  logic         nv_o;
  logic         nx_o;

  int checks = 0;
  int errors = 0;

  fp_to_int_seq #(
    .INT_WIDTH (W),
    .SHIFT_STEP(STEP)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .operand_i(operand_i),
    .signed_i (signed_i),
`ifdef FP2INT_RTZ_EN
    .rtz_i    (rtz_i),
`endif
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .nv_o     (nv_o),
    .nx_o     (nx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0]  op;
    bit           sgnd;
    logic [W-1:0] res;
    bit           nv;
    bit           nx;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Exact arithmetic model: value = (128+m) * 2^(e-7), rounded to nearest-even.
  function automatic void ref_conv(input logic [15:0] op, input bit sgnd,
                                   output logic [W-1:0] res, output bit nv,
                                   output bit nx, output int lat);
    bit     sgn, inex, up;
    int     ex, m, e, sh, k;
    longint sig, q, rem, half, v, maxp, minn;
    sgn  = op[15];
    ex   = int'(op[14:7]);
    m    = int'(op[6:0]);
    maxp = sgnd ? (longint'(1) << (W-1)) - 1 : (longint'(1) << W) - 1;
    minn = sgnd ? -(longint'(1) << (W-1)) : 0;
    nv = 0; nx = 0; lat = 1; res = '0;
    if (ex == 255) begin
      res = W'((m != 0 || !sgn) ? maxp : minn);
      nv  = 1;
      return;
    end
    if (ex == 0) begin
      nx = (m != 0);
      return;
    end
    e = ex - 127;
    if (e > W-1) begin
      res = W'(sgn ? minn : maxp);
      nv  = 1;
      return;
    end
    sh  = (W-1-e < W+1) ? W-1-e : W+1;
    lat = 2 + (sh + STEP - 1) / STEP;
    sig = 128 + m;
    up  = 0;
    if (e >= 7) begin
      q    = sig << (e - 7);
      inex = 0;
    end else begin
      k = 7 - e;
      if (k >= 10) begin
        q    = 0;
        inex = 1;
      end else begin
        q    = sig >> k;
        rem  = sig & ((longint'(1) << k) - 1);
        half = longint'(1) << (k - 1);
        inex = (rem != 0);
        up   = (rem > half) || ((rem == half) && (q % 2 == 1));
      end
    end
    q = q + (up ? 1 : 0);
    v = sgn ? -q : q;
    if (v > maxp || v < minn) begin
      res = W'(sgn ? minn : maxp);
      nv  = 1;
    end else begin
      res = W'(v);
      nx  = inex;
    end
  endfunction

  task automatic convert(input logic [15:0] op, input bit sgnd,
                         output logic [W-1:0] res, output bit nv,
                         output bit nx, output int lat);
    @(negedge clk_i);
    chk("ready_before_accept", 64'(ready_o), 64'd1);
    operand_i = op;
    signed_i  = sgnd;
    valid_i   = 1'b1;
    ready_i   = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i   = 1'b0;
    operand_i = 16'($urandom);
    signed_i  = ~sgnd;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL timeout: valid_o not seen for op %0h", op);
    end
    res = result_o;
    nv  = nv_o;
    nx  = nx_o;
    @(posedge clk_i);
    #1;
    chk("ready_after_handshake", 64'(ready_o), 64'd1);
    chk("valid_after_handshake", 64'(valid_o), 64'd0);
  endtask

  logic [W-1:0] r_res, m_res, held;
  bit           r_nv, r_nx, m_nv, m_nx;
  int           r_lat, m_lat, wait_cnt;
  logic [15:0]  rop;
  bit           rsg;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    operand_i = '0; signed_i = 1'b0;
`ifdef FP2INT_RTZ_EN
    rtz_i = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_flags", 64'({nv_o, nx_o}), 64'd0);
    rst_i = 1'b0;

    vecs.push_back('{16'h3FC0, 1, 32'h00000002, 0, 1, 10});
    vecs.push_back('{16'h4020, 1, 32'h00000002, 0, 1, 10});
    vecs.push_back('{16'hBF80, 1, 32'hFFFFFFFF, 0, 0, 10});
    vecs.push_back('{16'hBF80, 0, 32'h00000000, 1, 0, 10});
    vecs.push_back('{16'hCF00, 1, 32'h80000000, 0, 0, 2});
    vecs.push_back('{16'h4F00, 1, 32'h7FFFFFFF, 1, 0, 2});
    vecs.push_back('{16'h4F00, 0, 32'h80000000, 0, 0, 2});
    vecs.push_back('{16'hCF01, 1, 32'h80000000, 1, 0, 2});
    vecs.push_back('{16'h7FC0, 1, 32'h7FFFFFFF, 1, 0, 1});
    vecs.push_back('{16'h7FC0, 0, 32'hFFFFFFFF, 1, 0, 1});
    vecs.push_back('{16'h7F80, 0, 32'hFFFFFFFF, 1, 0, 1});
    vecs.push_back('{16'hFF80, 0, 32'h00000000, 1, 0, 1});
    vecs.push_back('{16'hFF80, 1, 32'h80000000, 1, 0, 1});
    vecs.push_back('{16'h0000, 1, 32'h00000000, 0, 0, 1});
    vecs.push_back('{16'h8000, 0, 32'h00000000, 0, 0, 1});
    vecs.push_back('{16'h0001, 1, 32'h00000000, 0, 1, 1});
    vecs.push_back('{16'h4F80, 0, 32'hFFFFFFFF, 1, 0, 1});
    vecs.push_back('{16'h3F00, 1, 32'h00000000, 0, 1, 10});
    vecs.push_back('{16'h3FC0, 0, 32'h00000002, 0, 1, 10});
    vecs.push_back('{16'hBF00, 0, 32'h00000000, 0, 1, 10});
    vecs.push_back('{16'hBF40, 0, 32'h00000000, 1, 0, 10});
    vecs.push_back('{16'h3E80, 1, 32'h00000000, 0, 1, 11});
    vecs.push_back('{16'h3C00, 1, 32'h00000000, 0, 1, 11});

    foreach (vecs[i]) begin
      convert(vecs[i].op, vecs[i].sgnd, r_res, r_nv, r_nx, r_lat);
      chk($sformatf("vec%0d_result", i), 64'(r_res), 64'(vecs[i].res));
      chk($sformatf("vec%0d_nv", i), 64'(r_nv), 64'(vecs[i].nv));
      chk($sformatf("vec%0d_nx", i), 64'(r_nx), 64'(vecs[i].nx));
      chk($sformatf("vec%0d_latency", i), 64'(r_lat), 64'(vecs[i].lat));
    end

`ifdef FP2INT_RTZ_EN
    rtz_i = 1'b1;
    convert(16'h3FC0, 1, r_res, r_nv, r_nx, r_lat);
    chk("rtz_1p5_result", 64'(r_res), 64'd1);
    chk("rtz_1p5_nx", 64'(r_nx), 64'd1);
    convert(16'h4F00, 1, r_res, r_nv, r_nx, r_lat);
    chk("rtz_ovf_result", 64'(r_res), 64'h7FFFFFFF);
    chk("rtz_ovf_nv", 64'(r_nv), 64'd1);
    rtz_i = 1'b0;
`endif

    // Consumer stalls for 5 cycles while a new request is offered.
    @(negedge clk_i);
    operand_i = 16'h3FC0; signed_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    operand_i = 16'h4F00;
    wait_cnt = 0;
    while (!valid_o && wait_cnt < 100) begin
      @(posedge clk_i);
      #1;
      wait_cnt++;
    end
    chk("stall_valid_seen", 64'(valid_o), 64'd1);
    held = result_o;
    chk("stall_first_result", 64'(held), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("stall%0d_valid", c), 64'(valid_o), 64'd1);
      chk($sformatf("stall%0d_ready", c), 64'(ready_o), 64'd0);
      chk($sformatf("stall%0d_result", c), 64'(result_o), 64'(held));
      chk($sformatf("stall%0d_flags", c), 64'({nv_o, nx_o}), 64'b01);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("stall_release_ready", 64'(ready_o), 64'd1);

    // Reset lands in the middle of SHIFT.
    @(negedge clk_i);
    operand_i = 16'h3FC0; signed_i = 1'b1; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_reset_busy", 64'(ready_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_result", 64'(result_o), 64'd0);
    chk("midrst_flags", 64'({nv_o, nx_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("postrst_no_output", 64'(valid_o), 64'd0);
    convert(16'h4020, 1, r_res, r_nv, r_nx, r_lat);
    chk("postrst_result", 64'(r_res), 64'd2);

    for (int n = 0; n < 300; n++) begin
      rop = 16'($urandom);
      if ($urandom_range(1, 0) == 1) rop[14:7] = 8'($urandom_range(165, 110));
      rsg = 1'($urandom);
      ref_conv(rop, rsg, m_res, m_nv, m_nx, m_lat);
      convert(rop, rsg, r_res, r_nv, r_nx, r_lat);
      chk($sformatf("rand_%04h_s%0d_result", rop, rsg), 64'(r_res), 64'(m_res));
      chk($sformatf("rand_%04h_s%0d_nv", rop, rsg), 64'(r_nv), 64'(m_nv));
      chk($sformatf("rand_%04h_s%0d_nx", rop, rsg), 64'(r_nx), 64'(m_nx));
      chk($sformatf("rand_%04h_s%0d_latency", rop, rsg), 64'(r_lat), 64'(m_lat));
      chk("rand_flags_exclusive", 64'(r_nv & r_nx), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
